// File: rtl/mem_arbiter.sv
// Round-robin two-requester sequencer for a single-port synchronous scratch memory.
// Define MEM_ARB_STATS_EN to build the saturating per-requester grant counters.
module mem_arbiter #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          err_a,
  output logic          err_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          mem_cs,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    gcnt_a,
  output logic [7:0]    gcnt_b
);

  // state   | meaning
  // IDLE    | arbitrate, latch the granted request
  // ACCESS  | memory strobes active for one cycle
  // CAPTURE | registered read data returning from memory
  // ACK     | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic          ptr, ptr_nx;
  logic          owner, owner_nx;
  logic          we_q, we_nx;
  logic          sel_b, sel_we, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          mem_cs_nx, mem_wr_nx, mem_rd_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx;
  logic          ack_a_nx, ack_b_nx, err_a_nx, err_b_nx;
  logic [DW-1:0] rdata_a_nx, rdata_b_nx;

  always_comb begin
    sel_b        = req_b && (!req_a || ptr);
    sel_we       = sel_b ? we_b : we_a;
    sel_addr     = sel_b ? addr_b : addr_a;
    sel_wdata    = sel_b ? wdata_b : wdata_a;
    in_range     = {1'b0, sel_addr} < LIMIT;
    state_nx     = state;
    ptr_nx       = ptr;
    owner_nx     = owner;
    we_nx        = we_q;
    mem_cs_nx    = 1'b0;
    mem_wr_nx    = 1'b0;
    mem_rd_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    ack_a_nx     = 1'b0;
    ack_b_nx     = 1'b0;
    err_a_nx     = 1'b0;
    err_b_nx     = 1'b0;
    rdata_a_nx   = rdata_a;
    rdata_b_nx   = rdata_b;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          owner_nx = sel_b;
          ptr_nx   = !sel_b;
          we_nx    = sel_we;
          if (in_range) begin
            state_nx     = ACCESS;
            mem_cs_nx    = 1'b1;
            mem_wr_nx    = sel_we;
            mem_rd_nx    = !sel_we;
            mem_addr_nx  = sel_addr;
            mem_wdata_nx = sel_wdata;
          end else begin
            // rejected address: straight to ACK, memory bus untouched
            state_nx = ACK;
            ack_a_nx = !sel_b;
            ack_b_nx = sel_b;
            err_a_nx = !sel_b;
            err_b_nx = sel_b;
            if (sel_b) rdata_b_nx = '0;
            else       rdata_a_nx = '0;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_nx = ACK;
          ack_a_nx = !owner;
          ack_b_nx = owner;
        end else begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nx = ACK;
        ack_a_nx = !owner;
        ack_b_nx = owner;
        if (owner) rdata_b_nx = mem_rdata;
        else       rdata_a_nx = mem_rdata;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      we_q      <= we_nx;
      mem_cs    <= mem_cs_nx;
      mem_wr    <= mem_wr_nx;
      mem_rd    <= mem_rd_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      ack_a     <= ack_a_nx;
      ack_b     <= ack_b_nx;
      err_a     <= err_a_nx;
      err_b     <= err_b_nx;
      rdata_a   <= rdata_a_nx;
      rdata_b   <= rdata_b_nx;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic grant_a, grant_b;
  assign grant_b = (state == IDLE) && sel_b;
  assign grant_a = (state == IDLE) && (req_a || req_b) && !sel_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_a <= '0;
      gcnt_b <= '0;
    end else begin
      if (grant_a && gcnt_a != 8'hFF) gcnt_a <= gcnt_a + 8'd1;
      if (grant_b && gcnt_b != 8'hFF) gcnt_b <= gcnt_b + 8'd1;
    end
  end
`else
  assign gcnt_a = '0;
  assign gcnt_b = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a behavioural memory and
// a per-requester scoreboard of expected ack results.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0, wdata_a = '0, wdata_b = '0;
  logic       ack_a, ack_b, err_a, err_b;
  logic [3:0] rdata_a, rdata_b;
  logic       mem_cs, mem_wr, mem_rd;
  logic [3:0] mem_addr, mem_wdata;
  logic [3:0] mem_rdata = '0;
  logic [7:0] gcnt_a, gcnt_b;

  mem_arbiter #(.AW(4), .DW(4), .DEPTH(9)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .gcnt_a(gcnt_a), .gcnt_b(gcnt_b)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [16];
  logic [3:0] ref_mem [16];

  always @(posedge clk) begin
    if (mem_cs && mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_cs && mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic       chk;
    logic       err;
    logic [3:0] rdata;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   order_q[$];
  exp_t ea, eb;
  int   vectors = 0, miscompares = 0;
  int   cs_cycles = 0, exp_cs = 0, grants_a = 0, grants_b = 0;
  bit   busy_a = 0, busy_b = 0, rel_a = 0, rel_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cs || mem_wr || mem_rd) begin
        vectors++;
        assert (mem_cs === 1'b1 && (mem_wr ^ mem_rd) === 1'b1) else begin
          miscompares++;
          $error("FAIL strobes cs=%b wr=%b rd=%b, required cs=1 with exactly one of wr/rd", mem_cs, mem_wr, mem_rd);
        end
      end
      if (mem_cs) cs_cycles++;
      if (ack_a) begin
        order_q.push_back(1'b0);
        vectors++;
        assert (qa.size() != 0) else begin
          miscompares++;
          $error("FAIL ack_a_spurious observed ack with no outstanding request, required none");
        end
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          vectors++;
          assert ({err_a, (ea.chk ? rdata_a : 4'h0)} === {ea.err, ea.rdata}) else begin
            miscompares++;
            $error("FAIL ack_a_data err/rdata observed %b/%h required %b/%h", err_a, rdata_a, ea.err, ea.rdata);
          end
        end
      end
      if (ack_b) begin
        order_q.push_back(1'b1);
        vectors++;
        assert (qb.size() != 0) else begin
          miscompares++;
          $error("FAIL ack_b_spurious observed ack with no outstanding request, required none");
        end
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          vectors++;
          assert ({err_b, (eb.chk ? rdata_b : 4'h0)} === {eb.err, eb.rdata}) else begin
            miscompares++;
            $error("FAIL ack_b_data err/rdata observed %b/%h required %b/%h", err_b, rdata_b, eb.err, eb.rdata);
          end
        end
      end
    end
  end

  task automatic push(input bit sb, input bit we, input logic [3:0] addr, input logic [3:0] wd);
    exp_t e;
    e.err   = (addr >= 4'd9);
    e.chk   = !we || e.err;
    e.rdata = (e.err || we) ? 4'h0 : ref_mem[addr];
    if (!e.err) begin
      exp_cs++;
      if (we) ref_mem[addr] = wd;
    end
    if (sb) begin qb.push_back(e); grants_b++; end
    else    begin qa.push_back(e); grants_a++; end
  endtask

  task automatic drive(input bit sb, input bit we, input logic [3:0] addr, input logic [3:0] wd);
    if (sb) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else    begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
  endtask

  // Issue one transaction with the arbiter idle; check latency, pulse width, strobe count.
  task automatic txn(input bit sb, input bit we, input logic [3:0] addr, input logic [3:0] wd,
                     input int lat, input string tag);
    int n;
    int cs0;
    bit got;
    push(sb, we, addr, wd);
    drive(sb, we, addr, wd);
    cs0 = cs_cycles;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = sb ? ack_b : ack_a;
    end
    vectors++;
    assert (n === lat) else begin
      miscompares++;
      $error("FAIL %s_latency observed %0d cycles required %0d", tag, n, lat);
    end
    @(posedge clk); #1;
    if (sb) req_b = 1'b0; else req_a = 1'b0;
    vectors++;
    assert ((sb ? ack_b : ack_a) === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_ack_width ack observed 1 after one cycle required 0", tag);
    end
    vectors++;
    assert (cs_cycles - cs0 === ((addr >= 4'd9) ? 0 : 1)) else begin
      miscompares++;
      $error("FAIL %s_cs_cycles observed %0d required %0d", tag, cs_cycles - cs0, (addr >= 4'd9) ? 0 : 1);
    end
  endtask

  task automatic rand_step(input bit allow);
    logic [3:0] ad, wd;
    bit w;
    @(posedge clk); #1;
    if (rel_a) begin req_a = 1'b0; busy_a = 0; rel_a = 0; end
    else if (busy_a && ack_a) rel_a = 1;
    if (rel_b) begin req_b = 1'b0; busy_b = 0; rel_b = 0; end
    else if (busy_b && ack_b) rel_b = 1;
    if (allow && !busy_a && $urandom_range(0, 2) == 0) begin
      w  = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 3));
      wd = 4'($urandom_range(0, 15));
      push(0, w, ad, wd);
      drive(0, w, ad, wd);
      busy_a = 1;
    end
    if (allow && !busy_b && $urandom_range(0, 2) == 0) begin
      w  = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(4, 8));
      wd = 4'($urandom_range(0, 15));
      push(1, w, ad, wd);
      drive(1, w, ad, wd);
      busy_b = 1;
    end
  endtask

  initial begin
    int n, na, nb, ga, gb;
    bit drop_a, drop_b;
    logic [3:0] ord;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 4'(15 - i);
      ref_mem[i] = 4'(15 - i);
    end

    repeat (2) @(posedge clk);
    #1;
    vectors++;
    assert ({ack_a, ack_b, err_a, err_b, rdata_a, rdata_b, mem_cs, mem_wr, mem_rd,
             mem_addr, mem_wdata, gcnt_a, gcnt_b} === 39'd0) else begin
      miscompares++;
      $error("FAIL reset_outputs some output observed nonzero, required all 0");
    end
    #2 rst = 1'b0;

    // Reset in the middle of an A write: strobes drop immediately, no ack follows.
    @(posedge clk); #1;
    drive(0, 1, 4'd7, 4'hC);
    @(posedge clk); #1;
    vectors++;
    assert ({mem_cs, mem_wr} === 2'b11) else begin
      miscompares++;
      $error("FAIL abort_access cs/wr observed %b%b required 11", mem_cs, mem_wr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    assert ({mem_cs, mem_wr, ack_a} === 3'b000) else begin
      miscompares++;
      $error("FAIL abort_drop cs/wr/ack observed %b%b%b required 000", mem_cs, mem_wr, ack_a);
    end
    req_a = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Contention from reset: A reads addr 2, B writes 5 to addr 2, both held.
    push(0, 0, 4'd2, 4'h0);
    push(1, 1, 4'd2, 4'h5);
    push(0, 0, 4'd2, 4'h0);
    push(1, 1, 4'd2, 4'h5);
    drive(0, 0, 4'd2, 4'h0);
    drive(1, 1, 4'd2, 4'h5);
    n = 0; na = 0; nb = 0; drop_a = 0; drop_b = 0;
    while ((req_a || req_b) && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (drop_a) begin req_a = 1'b0; drop_a = 0; end
      else if (ack_a) begin na++; if (na == 2) drop_a = 1; end
      if (drop_b) begin req_b = 1'b0; drop_b = 0; end
      else if (ack_b) begin nb++; if (nb == 2) drop_b = 1; end
    end
    vectors++;
    assert (n < 100) else begin
      miscompares++;
      $error("FAIL contention_timeout observed %0d cycles required < 100", n);
      req_a = 1'b0;
      req_b = 1'b0;
    end
    ord = 4'hF;
    for (int i = 0; i < 4 && i < order_q.size(); i++) ord[i] = order_q[i];
    vectors++;
    assert (order_q.size() === 4 && ord === 4'b1010) else begin
      miscompares++;
      $error("FAIL grant_order observed count %0d pattern %b (bit0 first, 1=B) required 4 and 1010",
             order_q.size(), ord);
    end
    order_q.delete();
    @(posedge clk); #1;
    ga = grants_a; gb = grants_b;
`ifndef MEM_ARB_STATS_EN
    ga = 0; gb = 0;
`endif
    vectors++;
    assert ({gcnt_a, gcnt_b} === {8'(ga), 8'(gb)}) else begin
      miscompares++;
      $error("FAIL gcnt_after_contention observed %0d/%0d required %0d/%0d", gcnt_a, gcnt_b, ga, gb);
    end

    txn(0, 1, 4'd3, 4'hA, 2, "wr_a3");
    txn(0, 0, 4'd3, 4'h0, 3, "rd_a3");
    txn(1, 0, 4'd9, 4'h0, 1, "rd_b9");
    txn(1, 0, 4'd15, 4'h0, 1, "rd_b15");
    txn(1, 0, 4'd8, 4'h0, 3, "rd_b8");
    txn(1, 1, 4'd8, 4'h6, 2, "wr_b8");
    txn(1, 0, 4'd8, 4'h0, 3, "rd_b8_again");
    txn(0, 1, 4'd12, 4'h3, 1, "wr_a12");

    for (int c = 0; c < 1000; c++) rand_step(1);
    for (int i = 0; i < 60 && (busy_a || busy_b); i++) rand_step(0);
    @(posedge clk); #1;
    vectors++;
    assert (!busy_a && !busy_b && qa.size() == 0 && qb.size() == 0) else begin
      miscompares++;
      $error("FAIL random_drain outstanding a=%0d b=%0d required 0/0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
      req_a = 1'b0;
      req_b = 1'b0;
      repeat (5) @(posedge clk);
      #1;
    end
    vectors++;
    assert (cs_cycles === exp_cs) else begin
      miscompares++;
      $error("FAIL cs_total observed %0d cycles required %0d", cs_cycles, exp_cs);
    end

    for (int i = 0; i < 300; i++) txn(0, 0, 4'd15, 4'h0, 1, "stat_a");
    ga = (grants_a > 255) ? 255 : grants_a;
    gb = (grants_b > 255) ? 255 : grants_b;
`ifndef MEM_ARB_STATS_EN
    ga = 0; gb = 0;
`endif
    vectors++;
    assert ({gcnt_a, gcnt_b} === {8'(ga), 8'(gb)}) else begin
      miscompares++;
      $error("FAIL gcnt_final observed %0d/%0d required %0d/%0d", gcnt_a, gcnt_b, ga, gb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
